// File: rtl/config_bus_arbiter.sv
// Round-robin arbiter serialising up to 4 requesters onto one config_addr/config_data write bus.
// Latency: ready and strobe start 1 cycle after the accepting edge; requests wait while a strobe/gap window is in progress.
module config_bus_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          STROBE_CYCLES = 1,
  parameter int          GAP_CYCLES    = 1,
  parameter logic [31:0] IDLE_ADDR     = 32'd0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*512-1:0] req_data,
  output logic [31:0]            config_addr,
  output logic [511:0]           config_data,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic [31:0]            write_count,
  output logic [15:0]            drop_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  localparam logic [1:0] LAST_IDX    = 2'(NUM_REQ - 1);
  localparam logic [3:0] STROBE_INIT = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_INIT    = 4'(GAP_CYCLES - 1);

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [1:0]           r_rr;
  logic [NUM_REQ-1:0]   r_ready;
  logic [31:0]          r_cfg_addr;
  logic [511:0]         r_cfg_data;
  logic                 r_busy;
  logic [1:0]           r_grant;
  logic [31:0]          r_wcnt;
  logic [15:0]          r_dcnt;

  logic [3:0]           w_valid;
  logic [31:0]          w_addr_arr [4];
  logic [511:0]         w_data_arr [4];
  logic                 w_any;
  logic [1:0]           w_winner;
  logic [NUM_REQ-1:0]   w_onehot;

  // Pad the flattened request buses to four slots so the winner index is always 2 bits wide.
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_used
      assign w_valid[g]    = req_valid[g];
      assign w_addr_arr[g] = req_addr[32*g +: 32];
      assign w_data_arr[g] = req_data[512*g +: 512];
    end else begin : g_unused
      assign w_valid[g]    = 1'b0;
      assign w_addr_arr[g] = '0;
      assign w_data_arr[g] = '0;
    end
  end

  always_comb begin
    logic [1:0] w_idx;
    w_any    = 1'b0;
    w_winner = 2'd0;
    w_idx    = r_rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
      w_idx = (w_idx == LAST_IDX) ? 2'd0 : w_idx + 2'd1;
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_onehot[i] = (w_winner == 2'(i));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rr       <= '0;
      r_ready    <= '0;
      r_cfg_addr <= IDLE_ADDR;
      r_cfg_data <= '0;
      r_busy     <= 1'b0;
      r_grant    <= '0;
      r_wcnt     <= '0;
      r_dcnt     <= '0;
    end else begin
      r_ready <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ready <= w_onehot;
            r_grant <= w_winner;
            r_rr    <= (w_winner == LAST_IDX) ? 2'd0 : w_winner + 2'd1;
            if (w_addr_arr[w_winner] != IDLE_ADDR) begin
              r_state    <= ST_DRIVE;
              r_cnt      <= STROBE_INIT;
              r_cfg_addr <= w_addr_arr[w_winner];
              r_cfg_data <= w_data_arr[w_winner];
              r_wcnt     <= r_wcnt + 32'd1;
              r_busy     <= 1'b1;
            end else if (r_dcnt != 16'hFFFF) begin
              r_dcnt <= r_dcnt + 16'd1;
            end
          end
        end
        ST_DRIVE: begin
          if (r_cnt == 4'd0) begin
            r_cfg_addr <= IDLE_ADDR;
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_INIT;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_cfg_addr <= IDLE_ADDR;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign config_addr = r_cfg_addr;
  assign config_data = r_cfg_data;
  assign busy        = r_busy;
  assign grant_id    = r_grant;
  assign write_count = r_wcnt;
  assign drop_count  = r_dcnt;

endmodule
